// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: direction counter encodings and the saturating counter step.
package bp_pkg;

    localparam logic [1:0] CTR_SNT  = 2'd0;
    localparam logic [1:0] CTR_WNT  = 2'd1;
    localparam logic [1:0] CTR_WT   = 2'd2;
    localparam logic [1:0] CTR_ST   = 2'd3;
    localparam logic [1:0] CTR_INIT = CTR_WT;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// Fetch-side lookup, execute-side update/flush and occupancy signals of the branch target buffer.
interface btb_assoc_if #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 3
);
    logic [XLEN-1:0] lk_pc;
    logic            lk_hit;
    logic            lk_taken;
    logic [XLEN-1:0] lk_target;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            flush;
    logic [IDX_W:0]  count;

    modport master (
        output lk_pc, upd_valid, upd_pc, upd_taken, upd_target, flush,
        input  lk_hit, lk_taken, lk_target, count
    );

    modport slave (
        input  lk_pc, upd_valid, upd_pc, upd_taken, upd_target, flush,
        output lk_hit, lk_taken, lk_target, count
    );
endinterface

// File: rtl/btb_prio_enc.sv
// Lowest-set-bit priority encoder with a found flag.
module btb_prio_enc #(
    parameter int IDX_W = 3
) (
    input  logic [(1<<IDX_W)-1:0] req,
    output logic [IDX_W-1:0]      idx,
    output logic                  found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = (1 << IDX_W) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/btb_assoc.sv
// Fully-associative BTB with 2-bit direction counters and occupancy count.
// Define BTB_LRU_EN for true-LRU replacement; otherwise a round-robin pointer picks the victim.
module btb_assoc
    import bp_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IDX_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    btb_assoc_if.slave  bus
);

    localparam int ENTRIES = 1 << IDX_W;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] tag;
        logic [XLEN-1:0] target;
        logic [1:0]      ctr;
    } btb_entry_t;

    btb_entry_t           entry_q [ENTRIES];
    btb_entry_t           entry_d [ENTRIES];
    logic [IDX_W:0]       count_q, count_d;
`ifdef BTB_LRU_EN
    logic [IDX_W-1:0]     age_q [ENTRIES];
    logic [IDX_W-1:0]     age_d [ENTRIES];
    logic                 touch;
    logic [IDX_W-1:0]     touch_idx;
`else
    logic [IDX_W-1:0]     ptr_q, ptr_d;
`endif

    logic [ENTRIES-1:0]   lk_match, upd_match, invalid;
    logic [IDX_W-1:0]     upd_idx, inv_idx, victim;
    logic                 upd_found, inv_found, alloc;
    logic                 lk_taken_c;
    logic [XLEN-1:0]      lk_target_c;

    always_comb begin
        lk_match  = '0;
        upd_match = '0;
        invalid   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            lk_match[i]  = entry_q[i].valid && (entry_q[i].tag == bus.lk_pc);
            upd_match[i] = entry_q[i].valid && (entry_q[i].tag == bus.upd_pc);
            invalid[i]   = !entry_q[i].valid;
        end
    end

    btb_prio_enc #(.IDX_W(IDX_W)) u_hit_enc (.req(upd_match), .idx(upd_idx), .found(upd_found));
    btb_prio_enc #(.IDX_W(IDX_W)) u_inv_enc (.req(invalid),   .idx(inv_idx), .found(inv_found));

    // Tags are unique, so the lookup match vector is at most one-hot and a plain select suffices.
    always_comb begin
        lk_taken_c  = 1'b0;
        lk_target_c = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (lk_match[i]) begin
                lk_taken_c  = entry_q[i].ctr[1];
                lk_target_c = entry_q[i].target;
            end
        end
    end

    assign bus.lk_hit    = |lk_match;
    assign bus.lk_taken  = lk_taken_c;
    assign bus.lk_target = lk_target_c;
    assign bus.count     = count_q;

    assign alloc = !bus.flush && bus.upd_valid && !upd_found && bus.upd_taken;

    always_comb begin
`ifdef BTB_LRU_EN
        victim = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (age_q[i] == {IDX_W{1'b1}}) victim = IDX_W'(i);
        end
`else
        victim = ptr_q;
`endif
        if (inv_found) victim = inv_idx;
    end

    always_comb begin
        entry_d = entry_q;
        count_d = count_q;
        if (bus.flush) begin
            for (int i = 0; i < ENTRIES; i++) entry_d[i].valid = 1'b0;
            count_d = '0;
        end else if (bus.upd_valid && upd_found) begin
            entry_d[upd_idx].ctr = ctr_next(entry_q[upd_idx].ctr, bus.upd_taken);
            if (bus.upd_taken) entry_d[upd_idx].target = bus.upd_target;
        end else if (alloc) begin
            entry_d[victim] = '{valid: 1'b1, tag: bus.upd_pc, target: bus.upd_target, ctr: CTR_INIT};
            if (inv_found) count_d = count_q + (IDX_W+1)'(1);
        end
    end

`ifdef BTB_LRU_EN
    // Touched entry becomes youngest; everything younger than it ages by one, keeping ages a permutation.
    always_comb begin
        age_d     = age_q;
        touch     = !bus.flush && bus.upd_valid && (upd_found || bus.upd_taken);
        touch_idx = upd_found ? upd_idx : victim;
        if (bus.flush) begin
            for (int i = 0; i < ENTRIES; i++) age_d[i] = IDX_W'(i);
        end else if (touch) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (age_q[i] < age_q[touch_idx]) age_d[i] = age_q[i] + IDX_W'(1);
            end
            age_d[touch_idx] = '0;
        end
    end
`else
    always_comb begin
        ptr_d = ptr_q;
        if (bus.flush) begin
            ptr_d = '0;
        end else if (alloc && !inv_found) begin
            ptr_d = ptr_q + IDX_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_q[i] <= '0;
`ifdef BTB_LRU_EN
                age_q[i]   <= IDX_W'(i);
`endif
            end
            count_q <= '0;
`ifndef BTB_LRU_EN
            ptr_q   <= '0;
`endif
        end else begin
            entry_q <= entry_d;
            count_q <= count_d;
`ifdef BTB_LRU_EN
            age_q   <= age_d;
`else
            ptr_q   <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Bench for btb_assoc (IDX_W = 2): recency-list/array model checked every cycle plus literal anchors.
// Honours BTB_LRU_EN the same way as the design.
module tb_btb_assoc;

    localparam int N = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    btb_assoc_if #(.XLEN(32), .IDX_W(2)) bus ();

    btb_assoc #(.XLEN(32), .IDX_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: plain arrays, a most-recent-first list and a round-robin index.
    bit          m_valid  [N];
    logic [31:0] m_tag    [N];
    logic [31:0] m_target [N];
    int          m_ctr    [N];
    int          rec[$];
    int          m_ptr;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = '0;
            m_target[i] = '0;
            m_ctr[i]    = 0;
        end
        rec.delete();
        for (int i = 0; i < N; i++) rec.push_back(i);
        m_ptr = 0;
    endtask

    task automatic touch(input int e);
        for (int k = 0; k < rec.size(); k++) begin
            if (rec[k] == e) begin
                rec.delete(k);
                break;
            end
        end
        rec.push_front(e);
    endtask

    task automatic model_step();
        int hit_e;
        int inv_e;
        int v;
        if (bus.flush) begin
            for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
            rec.delete();
            for (int i = 0; i < N; i++) rec.push_back(i);
            m_ptr = 0;
        end else if (bus.upd_valid) begin
            hit_e = -1;
            for (int i = 0; i < N; i++) if (m_valid[i] && m_tag[i] == bus.upd_pc) hit_e = i;
            if (hit_e >= 0) begin
                if (bus.upd_taken) begin
                    m_ctr[hit_e]    = (m_ctr[hit_e] < 3) ? m_ctr[hit_e] + 1 : 3;
                    m_target[hit_e] = bus.upd_target;
                end else begin
                    m_ctr[hit_e] = (m_ctr[hit_e] > 0) ? m_ctr[hit_e] - 1 : 0;
                end
                touch(hit_e);
            end else if (bus.upd_taken) begin
                inv_e = -1;
                for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) inv_e = i;
                if (inv_e >= 0) begin
                    v = inv_e;
                end else begin
`ifdef BTB_LRU_EN
                    v = rec[rec.size() - 1];
`else
                    v = m_ptr;
                    m_ptr = (m_ptr + 1) % N;
`endif
                end
                m_valid[v]  = 1'b1;
                m_tag[v]    = bus.upd_pc;
                m_target[v] = bus.upd_target;
                m_ctr[v]    = 2;
                touch(v);
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else      model_step();
    end

    // Mid-cycle comparison of every output against the reference.
    always @(negedge clk) begin
        logic        e_hit;
        logic        e_taken;
        logic [31:0] e_target;
        int          e_count;
        if (rst) begin
            e_hit = 1'b0; e_taken = 1'b0; e_target = '0; e_count = 0;
            for (int i = 0; i < N; i++) begin
                if (m_valid[i]) e_count++;
                if (m_valid[i] && m_tag[i] == bus.lk_pc) begin
                    e_hit    = 1'b1;
                    e_taken  = (m_ctr[i] >= 2);
                    e_target = m_target[i];
                end
            end
            checkOutput("model_lk_hit",    32'(bus.lk_hit),   32'(e_hit));
            checkOutput("model_lk_taken",  32'(bus.lk_taken), 32'(e_taken));
            checkOutput("model_lk_target", bus.lk_target,     e_target);
            checkOutput("model_count",     32'(bus.count),    32'(e_count));
        end
    end

    task automatic drive(input logic uv, input logic [31:0] upc, input logic ut,
                         input logic [31:0] utgt, input logic fl, input logic [31:0] lpc);
        bus.upd_valid  = uv;
        bus.upd_pc     = upc;
        bus.upd_taken  = ut;
        bus.upd_target = utgt;
        bus.flush      = fl;
        bus.lk_pc      = lpc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.upd_valid = 1'b0;
        bus.flush     = 1'b0;
        #1;
    endtask

    task automatic applyStimulus(input logic uv, input logic [31:0] upc, input logic ut,
                                 input logic [31:0] utgt, input logic fl, input logic [31:0] lpc);
        drive(uv, upc, ut, utgt, fl, lpc);
        step();
    endtask

    task automatic look(input logic [31:0] lpc);
        bus.lk_pc = lpc;
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b0, 32'h0);
        #3;
        checkOutput("reset_lk_hit",    32'(bus.lk_hit),    32'd0);
        checkOutput("reset_lk_target", bus.lk_target,      32'h0);
        checkOutput("reset_count",     32'(bus.count),     32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;

        applyStimulus(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h100);
        checkOutput("alloc_hit",    32'(bus.lk_hit),   32'd1);
        checkOutput("alloc_taken",  32'(bus.lk_taken), 32'd1);
        checkOutput("alloc_target", bus.lk_target,     32'h200);
        checkOutput("alloc_count",  32'(bus.count),    32'd1);

        applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h100);
        checkOutput("nt1_taken", 32'(bus.lk_taken), 32'd0);
        for (int k = 0; k < 2; k++) applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h100);
        checkOutput("nt3_hit",   32'(bus.lk_hit),   32'd1);
        checkOutput("nt3_taken", 32'(bus.lk_taken), 32'd0);

        applyStimulus(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h100);
        checkOutput("t1_taken_from_snt", 32'(bus.lk_taken), 32'd0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h100);
        checkOutput("t4_taken",  32'(bus.lk_taken), 32'd1);
        checkOutput("t4_target", bus.lk_target,     32'h200);
        applyStimulus(1'b1, 32'h100, 1'b1, 32'h300, 1'b0, 32'h100);
        checkOutput("retarget", bus.lk_target, 32'h300);

        applyStimulus(1'b1, 32'h500, 1'b0, 32'h900, 1'b0, 32'h500);
        checkOutput("ntmiss_hit",   32'(bus.lk_hit), 32'd0);
        checkOutput("ntmiss_count", 32'(bus.count),  32'd1);

        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 32'h100);
        checkOutput("flush_count", 32'(bus.count), 32'd0);
        for (int k = 1; k <= 4; k++)
            applyStimulus(1'b1, 32'(k * 16), 1'b1, 32'(k * 16 + 32'h1000), 1'b0, 32'h10);
        checkOutput("fill_count", 32'(bus.count), 32'd4);
        applyStimulus(1'b1, 32'h10, 1'b1, 32'h1010, 1'b0, 32'h10);
        applyStimulus(1'b1, 32'h50, 1'b1, 32'h1050, 1'b0, 32'h50);
        checkOutput("repl_count", 32'(bus.count), 32'd4);
        checkOutput("repl_new_hit", 32'(bus.lk_hit), 32'd1);
`ifdef BTB_LRU_EN
        look(32'h10);  checkOutput("lru_keep_10",  32'(bus.lk_hit), 32'd1);
        look(32'h20);  checkOutput("lru_evict_20", 32'(bus.lk_hit), 32'd0);
`else
        look(32'h10);  checkOutput("rr_evict_10",  32'(bus.lk_hit), 32'd0);
        look(32'h20);  checkOutput("rr_keep_20",   32'(bus.lk_hit), 32'd1);
`endif
        applyStimulus(1'b1, 32'h70, 1'b1, 32'h1070, 1'b0, 32'h70);
`ifdef BTB_LRU_EN
        look(32'h30);  checkOutput("lru_evict_30", 32'(bus.lk_hit), 32'd0);
`else
        look(32'h20);  checkOutput("rr_ptr1_evict_20", 32'(bus.lk_hit), 32'd0);
`endif
        checkOutput("repl2_count", 32'(bus.count), 32'd4);

        applyStimulus(1'b1, 32'h60, 1'b1, 32'h1060, 1'b1, 32'h10);
        checkOutput("flushupd_count", 32'(bus.count),  32'd0);
        checkOutput("flushupd_hit10", 32'(bus.lk_hit), 32'd0);
        look(32'h60);
        checkOutput("flushupd_hit60", 32'(bus.lk_hit), 32'd0);

        applyStimulus(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h100);
        drive(1'b1, 32'h100, 1'b1, 32'h400, 1'b0, 32'h100);
        #1;
        checkOutput("bypass_old_target", bus.lk_target, 32'h200);
        step();
        checkOutput("bypass_new_target", bus.lk_target, 32'h400);

        rst = 1'b0;
        #1;
        checkOutput("areset_hit",    32'(bus.lk_hit),   32'd0);
        checkOutput("areset_taken",  32'(bus.lk_taken), 32'd0);
        checkOutput("areset_target", bus.lk_target,     32'h0);
        checkOutput("areset_count",  32'(bus.count),    32'd0);
        #1 rst = 1'b1;
        step();
        applyStimulus(1'b1, 32'h900, 1'b1, 32'h940, 1'b0, 32'h900);
        checkOutput("post_reset_target", bus.lk_target, 32'h940);
        checkOutput("post_reset_count",  32'(bus.count), 32'd1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
